// File: rtl/ifu_ib_tx_pkg.sv
// Shared types and helpers for the fetch-to-instruction-buffer transmitter.
package ifu_pkg;

  localparam int unsigned FP_SLOTS       = 4;
  localparam int unsigned IFU_PC_WIDTH   = 64;
  localparam int unsigned IFU_INST_WIDTH = 32;

  typedef logic [IFU_PC_WIDTH-1:0]   pc_t;
  typedef logic [IFU_INST_WIDTH-1:0] inst_t;

  // One fetch packet as held in the packet queue.
  typedef struct packed {
    pc_t                       base_pc;
    inst_t [FP_SLOTS-1:0]      insts;
    logic [1:0]                start;
    logic [1:0]                last;
  } fq_entry_t;

  // How many entries leave the queue head this cycle.
  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2
  } pop_e;

  function automatic pc_t ifu_slot_pc(input pc_t base, input logic [1:0] slot);
    return base + {{(IFU_PC_WIDTH-4){1'b0}}, slot, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_ib_tx_if.sv
// Fetch-packet input and ifu_i0/ifu_i1 output bundle of the transmitter.
interface ifu_ib_tx_if #(
  parameter int unsigned PC_WIDTH   = 64,
  parameter int unsigned INST_WIDTH = 32
);
  logic                    flush;
  logic                    fp_valid;
  logic                    fp_ready;
  logic [PC_WIDTH-1:0]     fp_pc;
  logic [1:0]              fp_last;
  logic [4*INST_WIDTH-1:0] fp_insts;
  logic                    deu_ib2_val;
  logic                    deu_ib3_val;
  logic                    ifu_i0_valid;
  logic [PC_WIDTH-1:0]     ifu_i0_pc;
  logic [INST_WIDTH-1:0]   ifu_i0_inst;
  logic                    ifu_i1_valid;
  logic [PC_WIDTH-1:0]     ifu_i1_pc;
  logic [INST_WIDTH-1:0]   ifu_i1_inst;

  modport master (
    output flush, fp_valid, fp_pc, fp_last, fp_insts, deu_ib2_val, deu_ib3_val,
    input  fp_ready, ifu_i0_valid, ifu_i0_pc, ifu_i0_inst,
           ifu_i1_valid, ifu_i1_pc, ifu_i1_inst
  );

  modport slave (
    input  flush, fp_valid, fp_pc, fp_last, fp_insts, deu_ib2_val, deu_ib3_val,
    output fp_ready, ifu_i0_valid, ifu_i0_pc, ifu_i0_inst,
           ifu_i1_valid, ifu_i1_pc, ifu_i1_inst
  );
endinterface

// File: rtl/ifu_fq_mem.sv
// Fetch packet queue storage: circular register array, push and pop-1/pop-2.
module ifu_fq_mem
  import ifu_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      push,
  input  fq_entry_t push_entry,
  input  pop_e      pop,
  output fq_entry_t head,
  output fq_entry_t second,
  output logic      head_valid,
  output logic      second_valid,
  output logic      full
);
  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd_nxt;
  logic [CW-1:0] cnt_q, cnt_d, pop_n;
  fq_entry_t     mem_q [FQ_DEPTH];
  fq_entry_t     mem_d [FQ_DEPTH];

  // Pointer, count and array next-state.
  always_comb begin
    mem_d = mem_q;
    case (pop)
      POP_ONE: pop_n = CW'(1);
      POP_TWO: pop_n = CW'(2);
      default: pop_n = '0;
    endcase
    rd_nxt = rd_q + 1'b1;
    rd_d   = rd_q + pop_n[PW-1:0];
    wr_d   = wr_q;
    if (push) begin
      mem_d[wr_q] = push_entry;
      wr_d        = wr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(push) - pop_n;
    if (clr) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
    head         = mem_q[rd_q];
    second       = mem_q[rd_nxt];
    head_valid   = (cnt_q != '0);
    second_valid = (cnt_q >= CW'(2));
    full         = (cnt_q == CW'(FQ_DEPTH));
  end

  // Queue state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < FQ_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/ifu_ib_tx.sv
// Fetch-side transmitter: queues fetch packets and emits up to two
// program-ordered instructions per cycle within instruction buffer credit.
module ifu_ib_tx
  import ifu_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = IFU_PC_WIDTH,
  parameter int unsigned INST_WIDTH = IFU_INST_WIDTH,
  parameter int unsigned FQ_DEPTH   = 4
) (
  input logic         clk,
  input logic         rst,
  ifu_ib_tx_if.slave  bus
);
  fq_entry_t head, second, push_entry;
  logic      head_valid, second_valid, full, push;
  pop_e      pop;

  // hs_fresh_q set means the head entry is new and its start slot is the
  // current slot; this avoids needing the entry after a double pop.
  logic [1:0] hs_q, hs_d, hs_eff;
  logic       hs_fresh_q, hs_fresh_d;

  logic [2:0] head_rem, next_cnt;
  logic [3:0] avail;
  logic [1:0] credit, n;
  logic [1:0] i1_slot;
  logic       i1_in_head, v0, v1;
  pc_t        pc0, pc1;
  inst_t      inst0, inst1;
  logic       unused_pc_bits;

  assign unused_pc_bits = ^bus.fp_pc[1:0];

  ifu_fq_mem #(.FQ_DEPTH(FQ_DEPTH)) u_fq (
    .clk          (clk),
    .rst          (rst),
    .clr          (bus.flush),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (pop),
    .head         (head),
    .second       (second),
    .head_valid   (head_valid),
    .second_valid (second_valid),
    .full         (full)
  );

  // Packet capture, credit, emit count, selection and head slot update.
  always_comb begin
    push                = bus.fp_valid & ~full & ~bus.flush;
    push_entry.base_pc  = {bus.fp_pc[PC_WIDTH-1:4], 4'b0000};
    for (int unsigned k = 0; k < FP_SLOTS; k++)
      push_entry.insts[k] = bus.fp_insts[k*INST_WIDTH +: INST_WIDTH];
    push_entry.start    = bus.fp_pc[3:2];
    push_entry.last     = bus.fp_last;

    hs_eff   = hs_fresh_q ? head.start : hs_q;
    head_rem = {1'b0, head.last} - {1'b0, hs_eff} + 3'd1;
    next_cnt = second_valid ? ({1'b0, second.last} - {1'b0, second.start} + 3'd1) : 3'd0;
    avail    = head_valid ? ({1'b0, head_rem} + {1'b0, next_cnt}) : 4'd0;

    if (bus.deu_ib3_val)      credit = 2'd0;
    else if (bus.deu_ib2_val) credit = 2'd1;
    else                      credit = 2'd2;

    n = 2'd2;
    if (credit < n)          n = credit;
    if (avail < {2'b00, n})  n = avail[1:0];
    if (bus.flush)           n = 2'd0;

    v0 = (n != 2'd0);
    v1 = (n == 2'd2);

    i1_in_head = (hs_eff < head.last);
    i1_slot    = i1_in_head ? (hs_eff + 2'd1) : second.start;
    pc0        = {PC_WIDTH{v0}} & ifu_slot_pc(head.base_pc, hs_eff);
    inst0      = {INST_WIDTH{v0}} & head.insts[hs_eff];
    pc1        = {PC_WIDTH{v1}} & (i1_in_head ? ifu_slot_pc(head.base_pc, i1_slot)
                                              : ifu_slot_pc(second.base_pc, i1_slot));
    inst1      = {INST_WIDTH{v1}} & (i1_in_head ? head.insts[i1_slot]
                                                : second.insts[i1_slot]);

    pop        = POP_NONE;
    hs_d       = hs_q;
    hs_fresh_d = hs_fresh_q;
    if (n != 2'd0) begin
      if ({1'b0, n} == head_rem) begin
        pop        = POP_ONE;
        hs_d       = '0;
        hs_fresh_d = 1'b1;
      end else if ({1'b0, n} > head_rem) begin
        // Pair spilled one instruction into the next entry.
        if (next_cnt == 3'd1) begin
          pop        = POP_TWO;
          hs_d       = '0;
          hs_fresh_d = 1'b1;
        end else begin
          pop        = POP_ONE;
          hs_d       = second.start + 2'd1;
          hs_fresh_d = 1'b0;
        end
      end else begin
        hs_d       = hs_eff + n;
        hs_fresh_d = 1'b0;
      end
    end
    if (bus.flush) begin
      pop        = POP_NONE;
      hs_d       = '0;
      hs_fresh_d = 1'b1;
    end
  end

  // Head slot pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q       <= '0;
      hs_fresh_q <= 1'b1;
    end else begin
      hs_q       <= hs_d;
      hs_fresh_q <= hs_fresh_d;
    end
  end

  assign bus.fp_ready     = ~full;
  assign bus.ifu_i0_valid = v0;
  assign bus.ifu_i0_pc    = pc0;
  assign bus.ifu_i0_inst  = inst0;
  assign bus.ifu_i1_valid = v1;
  assign bus.ifu_i1_pc    = pc1;
  assign bus.ifu_i1_inst  = inst1;
endmodule

// File: doc/ifu_ib_tx.md
Name: ifu_ib_tx

Overview:
- Fetch-side transmitter that feeds the decode instruction buffer through the ifu_i0/ifu_i1 interface.
- Holds fetch packets from the I-cache datapath, each 4 instructions at 16-byte alignment, in a small packet queue.
- Every cycle, emits up to two program-ordered instructions with their PCs.
- Emission is gated by the instruction buffer's occupancy flags; the buffer has no ready/stall return, so this block guarantees that every emitted instruction is accepted.

Parameters:
- PC_WIDTH, 64, PC width in bits (`LA64_PC_WIDTH).
- INST_WIDTH, 32, instruction width in bits (`LA64_INST_WIDTH).
- FQ_DEPTH, 4, packet queue entries; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  redirect; discard all queued and in-flight instructions
- fp_valid  in  1  fetch packet valid
- fp_ready  out  1  queue can accept a packet
- fp_pc  in  PC_WIDTH  PC of first useful instruction; [3:2] is the start slot
- fp_last  in  2  last useful slot, for taken-branch truncation; fp_last ≥ fp_pc[3:2]
- fp_insts  in  4*INST_WIDTH  slot k occupies bits [32k+31:32k]
- deu_ib2_val  in  1  instruction buffer entry 2 occupied
- deu_ib3_val  in  1  instruction buffer entry 3 occupied
- ifu_i0_valid  out  1  older instruction valid
- ifu_i0_pc  out  PC_WIDTH  PC of i0
- ifu_i0_inst  out  INST_WIDTH  instruction i0
- ifu_i1_valid  out  1  younger instruction valid
- ifu_i1_pc  out  PC_WIDTH  PC of i1
- ifu_i1_inst  out  INST_WIDTH  instruction i1

Behaviour:
- Reset (rst=1 at a clock edge):
  - queue empty, head slot pointer 0, rd/wr pointers 0.
  - The following cycle: ifu_i0_valid=ifu_i1_valid=0, fp_ready=1.
- Queue entry contents: base PC {fp_pc[PC_WIDTH-1:4],4'b0}, four instructions, start slot = fp_pc[3:2], last slot = fp_last.
- Write: fp_valid & fp_ready & ~flush pushes an entry. fp_ready = ~full. No bypass: fill-to-output latency is exactly 1 cycle.
- Credit, from the buffer flags (entries fill contiguously, so ib3 implies ib2):
  - ib3=1 → credit 0
  - ib2=1, ib3=0 → credit 1
  - otherwise → credit 2
- Head slot pointer hs: loaded with the start slot when an entry becomes head. Available instructions: avail = (head.last − hs + 1) + (second entry valid ? second.last − second.start + 1 : 0).
- Emit count n = min(credit, avail, 2); forced to 0 when flush=1.
  - ifu_i0_valid = (n≥1); ifu_i1_valid = (n==2). i1 is never valid without i0.
- Instruction selection:
  - i0 = head slot hs, PC = head.base + 4*hs.
  - i1 = head slot hs+1 when hs < head.last; otherwise the next entry's start slot, PC = next.base + 4*next.start (pair crosses a packet boundary).
- Invalid outputs: PC and inst are don't-care but driven as 0 (AND-OR mux style).
- Pointer update after emitting n:
  - If head's remaining instructions ≤ n, pop head.
  - If the pair consumed all of head and one instruction of the next entry, pop once and set hs = next.start+1. Set hs = next.start+2 only if that case arises; it cannot, since n ≤ 2.
  - If a popped next entry has a single instruction and was consumed, pop twice.
  - Otherwise hs += n.
- Simultaneous push and pop(s) in one cycle are legal.
- Full condition: count == FQ_DEPTH. The count register width is clog2(FQ_DEPTH)+1.
- Flush: outputs invalid and fp push dropped that cycle. Next cycle the queue is empty, hs=0, fp_ready=1. A new packet may be pushed the cycle after flush.
- Flush or rst mid-pair: no partial state remains; rst has priority over flush.
- Outputs are combinational from queue flops and deu_ib*_val, which are themselves flop outputs of the buffer, so no combinational loop exists.

Decomposition:
- Shared package ifu_pkg:
  - typedef fq_entry_t {base_pc, insts[4], start, last}
  - constant FP_SLOTS=4
  - function ifu_slot_pc(base, slot)
- One natural sub-module: ifu_fq_mem, the FQ_DEPTH-entry register array with push/pop-1/pop-2 pointer logic and count. The top handles credit, selection and hs.

Test Plan:
- Reset then empty: rst for 2 cycles, no fp → fp_ready=1; both valids 0 for 10 cycles.
- Single packet, free buffer: push pc=0x1000, last=3, insts A,B,C,D; ib2=ib3=0.
  - Cycle+1: i0=A@0x1000, i1=B@0x1004.
  - Cycle+2: C@0x1008, D@0x100C.
  - Cycle+3: both valids 0.
- Credit gating: same packet with ib2=1, ib3=0 → only i0 valid per cycle (A, B, C, D over 4 cycles); with ib3=1 → no valids while held.
- Boundary cross: push pc=0x200C (last=3, inst X), then pc=0x3004 (last=2, inst Y@slot1, Z@slot2).
  - Pair 1: X@0x200C, Y@0x3004.
  - Next: Z@0x3008 alone.
- Truncated and full queue:
  - Push FQ_DEPTH packets with ib3=1 held → fp_ready=0 after the 4th push; a 5th fp_valid is held off.
  - Release credit → drains in order; fp_ready=1 the cycle after the first pop.
  - Packet pc=0x4008, last=2 emits only slot2@0x4008.
- Flush mid-stream: flush while 3 packets are queued and fp_valid=1 → valids 0 that cycle. Next cycle queue empty, fp_ready=1, and the next packet appears 1 cycle after its push.
